// File: rtl/adc_word_aligner.sv
// adc_word_aligner
// Aligns the 24-bit deserialized ADC word by searching for the bit offset at
// which the ADC test pattern appears. Once locked, it keeps that offset and
// counts pattern errors on request. Data always flows at the current offset.
module adc_word_aligner #(
  parameter logic [11:0] P_PAT_0    = 12'hF0C,
  parameter logic [11:0] P_PAT_1    = 12'h0A3,
  parameter int          P_SETTLE   = 2,
  parameter int          P_LOCK_CNT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] raw_in,
  input  logic        train_req,
  input  logic        chk_en,
  input  logic        err_clr,
  output logic [11:0] adc_samp_0,
  output logic [11:0] adc_samp_1,
  output logic        samp_valid,
  output logic [4:0]  offset,
  output logic        train_busy,
  output logic        locked,
  output logic        lock_fail,
  output logic [15:0] err_cnt
);

  localparam int SW = $clog2(P_SETTLE + 1);
  localparam int MW = $clog2(P_LOCK_CNT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(P_SETTLE - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(P_LOCK_CNT - 1);
  localparam logic [23:0]   PATTERN     = {P_PAT_1, P_PAT_0};
  localparam logic [4:0]    OFFSET_MAX  = 5'd23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t          state_reg, state_next;
  logic [4:0]      offset_reg, offset_next;
  logic [SW-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [MW-1:0]   match_cnt_reg, match_cnt_next;
  logic [15:0]     err_cnt_reg, err_cnt_next;
  logic [23:0]     raw_prev_reg;
  logic [23:0]     aligned_q_reg;
  logic [47:0]     window;
  logic [23:0]     aligned;
  logic            pat_match;

  // Two consecutive words cover every possible 24-bit alignment
  assign window    = {raw_in, raw_prev_reg};
  assign aligned   = window[offset_reg +: 24];
  assign pat_match = (aligned_q_reg == PATTERN);

  // Datapath: previous word and registered aligned word (one cycle latency)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_prev_reg  <= '0;
      aligned_q_reg <= '0;
    end else begin
      raw_prev_reg  <= raw_in;
      aligned_q_reg <= aligned;
    end
  end

  // State register plus the counters and offset it owns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      offset_reg     <= '0;
      settle_cnt_reg <= '0;
      match_cnt_reg  <= '0;
      err_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      offset_reg     <= offset_next;
      settle_cnt_reg <= settle_cnt_next;
      match_cnt_reg  <= match_cnt_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

  // Next-state logic: offset search, lock detection and error counting
  always_comb begin
    state_next      = state_reg;
    offset_next     = offset_reg;
    settle_cnt_next = settle_cnt_reg;
    match_cnt_next  = match_cnt_reg;
    err_cnt_next    = err_cnt_reg;

    if (train_req) begin
      // A training request restarts the search from any state
      state_next      = ST_SETTLE;
      offset_next     = '0;
      settle_cnt_next = '0;
      match_cnt_next  = '0;
    end else begin
      case (state_reg)
        ST_SETTLE: begin
          settle_cnt_next = settle_cnt_reg + SW'(1);
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next     = ST_CHECK;
            match_cnt_next = '0;
          end
        end
        ST_CHECK: begin
          if (pat_match) begin
            match_cnt_next = match_cnt_reg + MW'(1);
            if (match_cnt_reg == MATCH_LAST) begin
              state_next = ST_LOCKED;
            end
          end else if (offset_reg < OFFSET_MAX) begin
            // Ascending search: the lowest matching offset wins
            offset_next     = offset_reg + 5'd1;
            settle_cnt_next = '0;
            state_next      = ST_SETTLE;
          end else begin
            state_next = ST_FAIL;
          end
        end
        default: begin
        end
      endcase
    end

    // Clearing beats a same-cycle increment; counting only while locked
    if (err_clr || train_req) begin
      err_cnt_next = '0;
    end else if ((state_reg == ST_LOCKED) && chk_en && !pat_match &&
                 (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_next = err_cnt_reg + 16'd1;
    end
  end

  // Output decode: status flags follow the state directly
  always_comb begin
    train_busy = (state_reg == ST_SETTLE) || (state_reg == ST_CHECK);
    locked     = (state_reg == ST_LOCKED);
    lock_fail  = (state_reg == ST_FAIL);
    samp_valid = (state_reg == ST_LOCKED);
  end

  assign adc_samp_0 = aligned_q_reg[11:0];
  assign adc_samp_1 = aligned_q_reg[23:12];
  assign offset     = offset_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_adc_word_aligner.sv
// Directed bench for adc_word_aligner: skewed pattern streams, timing of lock,
// failure search, error counting and training restarts.
module tb_adc_word_aligner;

  logic        clk;
  logic        rst_n;
  logic [23:0] raw_in;
  logic        train_req;
  logic        chk_en;
  logic        err_clr;
  logic [11:0] adc_samp_0;
  logic [11:0] adc_samp_1;
  logic        samp_valid;
  logic [4:0]  offset;
  logic        train_busy;
  logic        locked;
  logic        lock_fail;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] PAT = 24'h0A3F0C;
  localparam logic [23:0] FLIP = 24'h800000;

  adc_word_aligner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (raw_in),
    .train_req  (train_req),
    .chk_en     (chk_en),
    .err_clr    (err_clr),
    .adc_samp_0 (adc_samp_0),
    .adc_samp_1 (adc_samp_1),
    .samp_valid (samp_valid),
    .offset     (offset),
    .train_busy (train_busy),
    .locked     (locked),
    .lock_fail  (lock_fail),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream word whose aligned form at offset s is the test pattern
  function automatic logic [23:0] rol(input logic [23:0] v, input int s);
    logic [47:0] d;
    d = {v, v} << s;
    return d[47:24];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after the edge that sampled train_req; waits for lock
  task automatic wait_lock(input string tag, input int exp_cycles, input int bound);
    int n;
    int busy_gap;
    logic done;
    chk({tag, "_busy0"}, 32'(train_busy), 32'd1);
    chk({tag, "_lock0"}, 32'(locked), 32'd0);
    chk({tag, "_fail0"}, 32'(lock_fail), 32'd0);
    chk({tag, "_off0"}, 32'(offset), 32'd0);
    n = 0;
    busy_gap = 0;
    done = 1'b0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
      if (locked) done = 1'b1;
      else if (!train_busy) busy_gap++;
    end
    chk({tag, "_locked"}, 32'(locked), 32'd1);
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_busygap"}, 32'(busy_gap), 32'd0);
    $display("lock %s: cycles=%0d offset=%0d", tag, n, offset);
  endtask

  task automatic train(input string tag, input int exp_cycles, input int bound);
    train_req = 1'b1;
    @(negedge clk);
    train_req = 1'b0;
    wait_lock(tag, exp_cycles, bound);
  endtask

  initial begin
    int n;
    logic saw_lock;
    rst_n = 1'b0;
    raw_in = '0;
    train_req = 1'b0;
    chk_en = 1'b0;
    err_clr = 1'b0;

    // Power-on reset
    #12;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_valid", 32'(samp_valid), 32'd0);
    chk("rst_busy", 32'(train_busy), 32'd0);
    chk("rst_samp0", 32'(adc_samp_0), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    chk("idle_busy", 32'(train_busy), 32'd0);

    // Skew 7
    raw_in = rol(PAT, 7);
    step(2);
    train("off7", 39, 41);
    chk("off7_offset", 32'(offset), 32'd7);
    chk("off7_samp0", 32'(adc_samp_0), 32'hF0C);
    chk("off7_samp1", 32'(adc_samp_1), 32'h0A3);
    chk("off7_valid", 32'(samp_valid), 32'd1);

    // One-cycle latency: zero word enters, half-window appears first
    raw_in = 24'h000000;
    step(1);
    chk("lat_samp0_a", 32'(adc_samp_0), 32'hF0C);
    chk("lat_samp1_a", 32'(adc_samp_1), 32'h003);
    step(1);
    chk("lat_samp1_b", 32'(adc_samp_1), 32'h000);
    raw_in = rol(PAT, 7);
    step(2);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_offset", 32'(offset), 32'd0);
    chk("arst_samp0", 32'(adc_samp_0), 32'd0);
    chk("arst_samp1", 32'(adc_samp_1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    chk("arst_idle_busy", 32'(train_busy), 32'd0);
    chk("arst_idle_valid", 32'(samp_valid), 32'd0);

    // Skew 0 and skew 23
    raw_in = PAT;
    step(2);
    train("off0", 18, 19);
    chk("off0_offset", 32'(offset), 32'd0);
    raw_in = rol(PAT, 23);
    step(2);
    train("off23", 87, 89);
    chk("off23_offset", 32'(offset), 32'd23);

    // Never-matching stream (different popcount from the pattern)
    raw_in = 24'h123456;
    step(2);
    train_req = 1'b1;
    @(negedge clk);
    train_req = 1'b0;
    n = 0;
    while (!lock_fail && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("fail_flag", 32'(lock_fail), 32'd1);
    chk("fail_cycles", 32'(n), 32'd72);
    chk("fail_locked", 32'(locked), 32'd0);
    chk("fail_offset", 32'(offset), 32'd23);
    chk("fail_busy", 32'(train_busy), 32'd0);
    $display("fail search: cycles=%0d offset=%0d", n, offset);

    // Skew 3 with error checking
    chk_en = 1'b1;
    raw_in = rol(PAT, 3);
    step(2);
    train("off3", 27, 29);
    chk("off3_err0", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      raw_in = rol(PAT, 3) ^ FLIP;
      step(1);
      raw_in = rol(PAT, 3);
      step(3);
    end
    chk("err5", 32'(err_cnt), 32'd5);
    raw_in = rol(PAT, 3) ^ FLIP;
    step(1);
    raw_in = rol(PAT, 3);
    step(1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("errclr_prio", 32'(err_cnt), 32'd0);
    step(2);
    chk("errclr_hold", 32'(err_cnt), 32'd0);
    raw_in = rol(PAT, 3) ^ FLIP;
    step(70000);
    chk("err_sat", 32'(err_cnt), 32'hFFFF);
    $display("saturation: err_cnt=%0h", err_cnt);
    raw_in = rol(PAT, 3);
    chk_en = 1'b0;
    step(2);

    // Restart while checking offset 12, then retrain while locked
    raw_in = rol(PAT, 17);
    step(2);
    train_req = 1'b1;
    @(negedge clk);
    train_req = 1'b0;
    step(38);
    chk("mid_offset12", 32'(offset), 32'd12);
    chk("mid_busy", 32'(train_busy), 32'd1);
    train_req = 1'b1;
    @(negedge clk);
    train_req = 1'b0;
    wait_lock("off17", 69, 71);
    chk("off17_offset", 32'(offset), 32'd17);
    raw_in = rol(PAT, 19);
    step(2);
    train("off19", 75, 77);
    chk("off19_offset", 32'(offset), 32'd19);

    // Match run broken at match count 10 on skew 5
    raw_in = rol(PAT, 5);
    step(2);
    train_req = 1'b1;
    @(negedge clk);
    train_req = 1'b0;
    step(25);
    raw_in = rol(PAT, 5) ^ FLIP;
    step(1);
    raw_in = rol(PAT, 5);
    step(1);
    chk("brk_offset5", 32'(offset), 32'd5);
    step(1);
    chk("brk_offset6", 32'(offset), 32'd6);
    chk("brk_locked", 32'(locked), 32'd0);
    n = 0;
    saw_lock = 1'b0;
    while (!lock_fail && n < 70) begin
      @(negedge clk);
      n++;
      if (locked) saw_lock = 1'b1;
    end
    chk("brk_never_locked", 32'(saw_lock), 32'd0);
    chk("brk_fail", 32'(lock_fail), 32'd1);
    chk("brk_fail_cycles", 32'(n), 32'd54);
    $display("broken run: fail after %0d cycles", n);

    // train_req on the final matching cycle
    raw_in = PAT;
    step(2);
    train_req = 1'b1;
    @(negedge clk);
    train_req = 1'b0;
    step(17);
    chk("race_pre_locked", 32'(locked), 32'd0);
    train_req = 1'b1;
    @(negedge clk);
    train_req = 1'b0;
    chk("race_locked", 32'(locked), 32'd0);
    wait_lock("race_relock", 18, 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
